// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on magnitudes,
// WIDTH iterations plus one finalisation cycle, result registered until the next accepted start.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       operation,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [2:0]       op_q, op_d;
    logic             a_neg_q, a_neg_d, b_neg_q, b_neg_d;
    // hi/lo: product accumulator for multiply, remainder/quotient pair for divide.
    // arg: multiplicand magnitude for multiply, divisor magnitude for divide.
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, arg_q, arg_d, result_q, result_d;

    logic             a_signed, b_signed, ovf;
    logic [WIDTH-1:0] a_mag, b_mag, quot, rem;
    logic [WIDTH:0]   sum, shifted, diff;
    logic [2*WIDTH-1:0] prod;

    always_comb begin
        a_signed = (operation == 3'b001) || (operation == 3'b010) ||
                   (operation == 3'b100) || (operation == 3'b110);
        b_signed = (operation == 3'b001) || (operation == 3'b100) || (operation == 3'b110);
        a_mag    = (a_signed && operand_a[WIDTH-1]) ? -operand_a : operand_a;
        b_mag    = (b_signed && operand_b[WIDTH-1]) ? -operand_b : operand_b;

        sum      = {1'b0, hi_q} + (lo_q[0] ? {1'b0, arg_q} : '0);
        shifted  = {hi_q, lo_q[WIDTH-1]};
        diff     = shifted - {1'b0, arg_q};

        prod     = {hi_q, lo_q};
        if (a_neg_q ^ b_neg_q) prod = -prod;
        quot     = (a_neg_q ^ b_neg_q) ? -lo_q : lo_q;
        rem      = a_neg_q ? -hi_q : hi_q;
        // Most-negative dividend over -1: magnitude quotient is exactly 2^(WIDTH-1).
        ovf      = a_neg_q && b_neg_q && (arg_q == WIDTH'(1)) &&
                   (lo_q == {1'b1, {(WIDTH-1){1'b0}}});

        state_d  = state_q;
        count_d  = count_q;
        op_d     = op_q;
        a_neg_d  = a_neg_q;
        b_neg_d  = b_neg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        arg_d    = arg_q;
        result_d = result_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StRun;
                    count_d = '0;
                    op_d    = operation;
                    a_neg_d = a_signed && operand_a[WIDTH-1];
                    b_neg_d = b_signed && operand_b[WIDTH-1];
                    hi_d    = '0;
                    if (operation[2]) begin
                        lo_d  = a_mag;
                        arg_d = b_mag;
                    end else begin
                        lo_d  = b_mag;
                        arg_d = a_mag;
                    end
                end else if (state_q == StDone) begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                if (count_q != CW'(WIDTH)) begin
                    count_d = count_q + 1'b1;
                    if (op_q[2]) begin
                        if (!diff[WIDTH]) begin
                            hi_d = diff[WIDTH-1:0];
                            lo_d = {lo_q[WIDTH-2:0], 1'b1};
                        end else begin
                            hi_d = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
                            lo_d = {lo_q[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        hi_d = sum[WIDTH:1];
                        lo_d = {sum[0], lo_q[WIDTH-1:1]};
                    end
                end else begin
                    state_d = StDone;
                    count_d = '0;
                    case (op_q)
                        3'b000:                 result_d = prod[WIDTH-1:0];
                        3'b001, 3'b010, 3'b011: result_d = prod[2*WIDTH-1:WIDTH];
                        3'b100, 3'b101: begin
                            if (arg_q == '0)  result_d = '1;
                            else if (ovf)     result_d = {1'b1, {(WIDTH-1){1'b0}}};
                            else              result_d = quot;
                        end
                        default: begin
                            if (ovf && arg_q != '0) result_d = '0;
                            else                    result_d = rem;
                        end
                    endcase
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            count_q  <= '0;
            op_q     <= '0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            arg_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            op_q     <= op_d;
            a_neg_q  <= a_neg_d;
            b_neg_q  <= b_neg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            arg_q    <= arg_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == StRun);
    assign done   = (state_q == StDone);
    assign result = result_q;

endmodule
